// File: rtl/pc_fetch_seq.sv
// Multi-cycle fetch sequencer: owns the PC and runs each instruction through an imem
// handshake and then waits for the datapath's done strobe. `DELAY_SLOT_EN adds a MIPS branch delay slot.
module pc_fetch_seq #(
   parameter logic [29:0] RESET_PC      = 30'h0000_0C00,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        ex_done,
   input  logic        jump,
   input  logic [25:0] j_target,
   input  logic        branch,
   input  logic        zero,
   input  logic [29:0] br_target,
   output logic [29:0] pc,
   output logic        fetch_err
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERR} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [29:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic [7:0]  count_q, count_d;

   logic        redirect;
   logic [29:0] redirect_pc;
   logic [29:0] seq_pc;

`ifdef DELAY_SLOT_EN
   logic        pend_q, pend_d;
   logic [29:0] pend_pc_q, pend_pc_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0;
         instr_valid_q <= 1'b0;
         count_q       <= 8'h0;
`ifdef DELAY_SLOT_EN
         pend_q        <= 1'b0;
         pend_pc_q     <= 30'h0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         count_q       <= count_d;
`ifdef DELAY_SLOT_EN
         pend_q        <= pend_d;
         pend_pc_q     <= pend_pc_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH: begin
            if (imem_ack)
               state_d = EXEC;
            else if (count_q == TIMEOUT_LAST)
               state_d = ERR;
         end
         EXEC:    if (ex_done) state_d = FETCH;
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   // Jump keeps the top four bits of the current word address (the 256 MB region).
   always_comb begin
      redirect    = jump | (branch & zero);
      redirect_pc = jump ? {pc_q[29:26], j_target} : br_target;
      seq_pc      = pc_q + 30'd1;
   end

   always_comb begin
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      count_d       = count_q;
`ifdef DELAY_SLOT_EN
      pend_d        = pend_q;
      pend_pc_d     = pend_pc_q;
`endif
      if (state_q == FETCH) begin
         if (imem_ack) begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            count_d       = 8'h0;
         end else begin
            count_d = count_q + 8'd1;
         end
      end
      if (state_q == EXEC && ex_done) begin
`ifdef DELAY_SLOT_EN
         // The slot instruction always retires sequentially; its own redirect is dropped.
         if (pend_q) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
         end else if (redirect) begin
            pc_d      = seq_pc;
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc;
         end else begin
            pc_d = seq_pc;
         end
`else
         pc_d = redirect ? redirect_pc : seq_pc;
`endif
      end
   end

   always_comb begin
      imem_req    = (state_q == FETCH);
      fetch_err   = (state_q == ERR);
      imem_addr   = pc_q;
      pc          = pc_q;
      instr       = instr_q;
      instr_valid = instr_valid_q;
   end

endmodule
